serializador_morse: RTL and testbench
=====================================

Name: serializador_morse

Overview:
Parametrised successor to the combinational digit-to-Morse encoder. Accepts BCD digits (0-9) through a ready strobe, queues them in a FIFO, and keys them out serially on a single line with standard Morse timing. Each unit of Morse time is a programmable number of clock cycles. It also exposes the 5-bit code of the digit currently being sent. Sits between the digit source and the sounder/LED driver.

Parameters:
UNIDADE, 4, clock cycles per Morse time unit (>=1)
PROFUNDIDADE, 4, FIFO depth in digits (>=2, power of two)
GAP_DIGITO, 3, off-units after the last symbol of each digit (>=1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
ready  in  1  digit strobe; each high cycle is one write request
digito  in  4  BCD digit, sampled when ready=1
aceito  out  1  registered; high one cycle after a write is accepted
erro  out  1  registered; one-cycle pulse when a write is dropped (digito>9 or FIFO full)
cheio  out  1  FIFO count == PROFUNDIDADE
ocupado  out  1  FSM not in OCIOSO, or FIFO non-empty
linha  out  1  keyed Morse output, registered (1 = tone)
s1  out  5  code of the digit being sent; s1[4] is sent first; 1 = dash, 0 = dot; 0 when idle

Behaviour:
- Reset (async): linha, s1, aceito, erro = 0; FIFO emptied; cheio = 0; ocupado = 0; FSM = OCIOSO; counters = 0. Reset mid-transmission drops linha in the same instant and discards all queued digits.
- Code table: 0=11111, 1=01111, 2=00111, 3=00011, 4=00001, 5=00000, 6=10000, 7=11000, 8=11100, 9=11110.
- Write acceptance on edge with ready=1:
  - Accepted if digito<=9 and cheio=0 (cheio evaluated before any same-cycle pop). Then aceito=1 on the next cycle.
  - Otherwise nothing is queued and erro=1 on the next cycle.
  - Push and pop in the same edge when not full: count unchanged.
- FSM states: OCIOSO, SIMBOLO, PAUSA_SIMB, PAUSA_DIG.
  - OCIOSO: if FIFO non-empty, pop; load shift register and s1 with the code; load symbol index to 4; load unit counter with the on-duration of bit 4 (1 unit for dot, 3 units for dash); go to SIMBOLO; linha=1 from this edge.
  - SIMBOLO: linha=1; count down UNIDADE x units. At expiry:
    - if the index is >0, go to PAUSA_SIMB (1 unit off);
    - otherwise go to PAUSA_DIG (GAP_DIGITO units off).
  - PAUSA_SIMB: linha=0; at expiry, decrement the index and go to SIMBOLO with the on-duration of the next bit.
  - PAUSA_DIG: linha=0; at expiry, clear s1 and go to OCIOSO. The next digit is popped on the following edge, so there is 1 extra idle cycle between digits.
- Latency: accept edge E0, pop edge E1; linha rises after E1.
- Digit duration, from linha rise to the OCIOSO return: (sum of on-units + 4 + GAP_DIGITO) x UNIDADE cycles. With defaults: digit 5 takes 48 cycles, digit 0 takes 88 cycles.
- Counter widths: unit counter $clog2(3*UNIDADE+1); FIFO pointers wrap modulo PROFUNDIDADE; count is $clog2(PROFUNDIDADE+1) bits.
- Changes to ready or digito while sending never disturb the current digit.

Decomposition:
- Shared package morse_pkg holds:
  - FSM state enum;
  - function codigo_morse(digit) returning the 5-bit table, or an invalid flag for digits >9;
  - constants DUR_PONTO=1, DUR_TRACO=3, DUR_PAUSA_SIMB=1.
- One sub-module fila_digitos: synchronous 4-bit FIFO (PROFUNDIDADE), async reset, push/pop/cheio/vazio/count.

Test Plan:
1. Reset with ready=1, digito=3 held -> after reset release: linha=0, s1=0, ocupado=0. Next edge accepts 3; aceito pulses.
2. UNIDADE=2, write 5 -> linha shows 5 x (2 high, 2 low), plus 4 further low (GAP 3: 6 low total after the last dot). s1=00000 while sending; ocupado falls 24 cycles after linha rises.
3. UNIDADE=2, write 0 -> s1=11111; five 6-cycle highs separated by 2-cycle lows; total 44 cycles before OCIOSO.
4. PROFUNDIDADE=4, back-to-back writes 1,2,3,4,5,6 while the first is sending -> 1 is popped immediately. 2,3,4,5 are queued and cheio=1. 6 is dropped with erro pulsed. Output order is 1,2,3,4,5.
5. Write digito=12 and digito=15 -> erro pulses each time, aceito=0, FIFO count unchanged, linha stays 0.
6. Assert reset mid-dash of digit 8 with 2 digits queued -> linha=0 and s1=0 asynchronously; after release, ocupado=0 and no further keying.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared FSM state type, Morse timing constants and the digit-to-code table.
package morse_pkg;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    SIMBOLO    = 2'd1,
    PAUSA_SIMB = 2'd2,
    PAUSA_DIG  = 2'd3
  } estado_t;

  // Result of a table lookup: 5-bit code (MSB sent first, 1 = dash) plus
  // a flag for inputs that are not BCD digits.
  typedef struct packed {
    logic       invalido;
    logic [4:0] codigo;
  } consulta_t;

  localparam int DUR_PONTO      = 1;
  localparam int DUR_TRACO      = 3;
  localparam int DUR_PAUSA_SIMB = 1;

  function automatic logic digito_valido(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  function automatic consulta_t codigo_morse(input logic [3:0] d);
    consulta_t r;
    r.invalido = !digito_valido(d);
    case (d)
      4'd0:    r.codigo = 5'b11111;
      4'd1:    r.codigo = 5'b01111;
      4'd2:    r.codigo = 5'b00111;
      4'd3:    r.codigo = 5'b00011;
      4'd4:    r.codigo = 5'b00001;
      4'd5:    r.codigo = 5'b00000;
      4'd6:    r.codigo = 5'b10000;
      4'd7:    r.codigo = 5'b11000;
      4'd8:    r.codigo = 5'b11100;
      4'd9:    r.codigo = 5'b11110;
      default: r.codigo = 5'b00000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serializador_morse_fila_digitos.sv
// Small synchronous FIFO of 4-bit digits with show-ahead read data.
module fila_digitos
  import morse_pkg::*;
#(
  parameter int PROFUNDIDADE = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  push,
  input  logic                                  pop,
  input  logic [3:0]                            dado_in,
  output logic [3:0]                            dado_out,
  output logic                                  cheio,
  output logic                                  vazio,
  output logic [$clog2(PROFUNDIDADE+1)-1:0]     count
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int NW = $clog2(PROFUNDIDADE + 1);

  logic [3:0]    mem [PROFUNDIDADE];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign cheio    = (count == NW'(PROFUNDIDADE));
  assign vazio    = (count == '0);
  assign do_push  = push && !cheio;
  assign do_pop   = pop && !vazio;
  assign dado_out = mem[rd_ptr];

  // Storage array; contents are don't-care while the matching slot is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= dado_in;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serializador_morse.sv
// Queues BCD digits and keys them out as Morse on a single line.
module serializador_morse
  import morse_pkg::*;
#(
  parameter int UNIDADE      = 4,
  parameter int PROFUNDIDADE = 4,
  parameter int GAP_DIGITO   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic [3:0] digito,
  output logic       aceito,
  output logic       erro,
  output logic       cheio,
  output logic       ocupado,
  output logic       linha,
  output logic [4:0] s1
);

  localparam int CW = $clog2(3 * UNIDADE + 1);
  localparam int GW = $clog2(GAP_DIGITO + 1);
  localparam int NW = $clog2(PROFUNDIDADE + 1);

  // Counter reload values hold "cycles minus one" so expiry is at zero.
  localparam logic [CW-1:0] CICLOS_PONTO   = CW'(DUR_PONTO * UNIDADE - 1);
  localparam logic [CW-1:0] CICLOS_TRACO   = CW'(DUR_TRACO * UNIDADE - 1);
  localparam logic [CW-1:0] CICLOS_PAUSA   = CW'(DUR_PAUSA_SIMB * UNIDADE - 1);
  localparam logic [CW-1:0] CICLOS_UNIDADE = CW'(UNIDADE - 1);
  localparam logic [GW-1:0] GAP_INICIAL    = GW'(GAP_DIGITO - 1);

  estado_t       estado;
  estado_t       estado_prox;
  logic [CW-1:0] contador;
  logic [CW-1:0] contador_prox;
  logic [GW-1:0] unidades_gap;
  logic [GW-1:0] unidades_gap_prox;
  logic [2:0]    indice;
  logic [2:0]    indice_prox;
  logic [4:0]    deslocamento;
  logic [4:0]    deslocamento_prox;
  logic [4:0]    s1_prox;

  logic          escrita_ok;
  logic          pop;
  logic          vazio;
  logic [3:0]    dado_fila;
  logic [NW-1:0] nivel_fila;
  consulta_t     consulta_saida;

  assign escrita_ok     = ready && !cheio && digito_valido(digito);
  assign consulta_saida = codigo_morse(dado_fila);
  assign ocupado        = (estado != OCIOSO) || (nivel_fila != '0);

  fila_digitos #(
    .PROFUNDIDADE(PROFUNDIDADE)
  ) u_fila (
    .clk      (clk),
    .reset    (reset),
    .push     (escrita_ok),
    .pop      (pop),
    .dado_in  (digito),
    .dado_out (dado_fila),
    .cheio    (cheio),
    .vazio    (vazio),
    .count    (nivel_fila)
  );

  // Write handshake: one-cycle acknowledge or drop pulse per request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aceito <= 1'b0;
      erro   <= 1'b0;
    end else begin
      aceito <= escrita_ok;
      erro   <= ready && !escrita_ok;
    end
  end

  // Keying state, timers and the registered line/code outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      contador     <= '0;
      unidades_gap <= '0;
      indice       <= '0;
      deslocamento <= '0;
      s1           <= '0;
      linha        <= 1'b0;
    end else begin
      estado       <= estado_prox;
      contador     <= contador_prox;
      unidades_gap <= unidades_gap_prox;
      indice       <= indice_prox;
      deslocamento <= deslocamento_prox;
      s1           <= s1_prox;
      linha        <= (estado_prox == SIMBOLO);
    end
  end

  // Next-state logic; deslocamento[4] is always the symbol being keyed.
  always_comb begin
    estado_prox       = estado;
    contador_prox     = contador;
    unidades_gap_prox = unidades_gap;
    indice_prox       = indice;
    deslocamento_prox = deslocamento;
    s1_prox           = s1;
    pop               = 1'b0;
    case (estado)
      OCIOSO: begin
        if (!vazio) begin
          pop = 1'b1;
          if (!consulta_saida.invalido) begin
            deslocamento_prox = consulta_saida.codigo;
            s1_prox           = consulta_saida.codigo;
            indice_prox       = 3'd4;
            contador_prox     = consulta_saida.codigo[4] ? CICLOS_TRACO : CICLOS_PONTO;
            estado_prox       = SIMBOLO;
          end
        end
      end
      SIMBOLO: begin
        if (contador == '0) begin
          if (indice != 3'd0) begin
            contador_prox = CICLOS_PAUSA;
            estado_prox   = PAUSA_SIMB;
          end else begin
            contador_prox     = CICLOS_UNIDADE;
            unidades_gap_prox = GAP_INICIAL;
            estado_prox       = PAUSA_DIG;
          end
        end else begin
          contador_prox = contador - 1'b1;
        end
      end
      PAUSA_SIMB: begin
        if (contador == '0) begin
          indice_prox       = indice - 1'b1;
          deslocamento_prox = {deslocamento[3:0], 1'b0};
          contador_prox     = deslocamento[3] ? CICLOS_TRACO : CICLOS_PONTO;
          estado_prox       = SIMBOLO;
        end else begin
          contador_prox = contador - 1'b1;
        end
      end
      PAUSA_DIG: begin
        if (contador == '0) begin
          if (unidades_gap == '0) begin
            s1_prox     = '0;
            estado_prox = OCIOSO;
          end else begin
            unidades_gap_prox = unidades_gap - 1'b1;
            contador_prox     = CICLOS_UNIDADE;
          end
        end else begin
          contador_prox = contador - 1'b1;
        end
      end
      default: begin
        estado_prox = OCIOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_serializador_morse.sv
// Directed bench for serializador_morse with a scoreboard of expected codes.
module tb_serializador_morse;

  logic       clk;
  logic       reset;
  logic       ready;
  logic [3:0] digito;
  logic       aceito;
  logic       erro;
  logic       cheio;
  logic       ocupado;
  logic       linha;
  logic [4:0] s1;

  int vectors     = 0;
  int miscompares = 0;

  logic [4:0] sb [$];

  int         run_alto  = 0;
  int         run_baixo = 0;
  int         nsimb     = 0;
  logic [4:0] cod       = '0;
  logic [7:0] esperado;

  int n;
  int altos;

  serializador_morse #(
    .UNIDADE      (2),
    .PROFUNDIDADE (4),
    .GAP_DIGITO   (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .digito  (digito),
    .aceito  (aceito),
    .erro    (erro),
    .cheio   (cheio),
    .ocupado (ocupado),
    .linha   (linha),
    .s1      (s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] codigo_ref(input logic [3:0] d);
    case (d)
      4'd0:    return 5'b11111;
      4'd1:    return 5'b01111;
      4'd2:    return 5'b00111;
      4'd3:    return 5'b00011;
      4'd4:    return 5'b00001;
      4'd5:    return 5'b00000;
      4'd6:    return 5'b10000;
      4'd7:    return 5'b11000;
      4'd8:    return 5'b11100;
      4'd9:    return 5'b11110;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observado,
                             input logic [31:0] esperado_v);
    vectors++;
    assert (observado === esperado_v) else begin
      miscompares++;
      $error("[TB] FAIL %s: observado=%0h esperado=%0h", tag, observado, esperado_v);
    end
  endtask

  // One write request; checks the handshake pulse and records accepted digits.
  task automatic applyStimulus(input logic [3:0] d, input logic aceita);
    ready  = 1'b1;
    digito = d;
    @(negedge clk);
    checkOutput("aceito", aceito, aceita);
    checkOutput("erro", erro, !aceita);
    if (aceita) sb.push_back(codigo_ref(d));
    ready = 1'b0;
  endtask

  task automatic waitRise(input int limite);
    int c;
    c = 0;
    while (linha !== 1'b1 && c < limite) begin
      @(negedge clk);
      c++;
    end
    checkOutput("subida_linha", linha, 1);
  endtask

  task automatic waitIdle(input int limite, output int ciclos);
    ciclos = 0;
    while (ocupado !== 1'b0 && ciclos < limite) begin
      @(negedge clk);
      ciclos++;
    end
    checkOutput("timeout_ocioso", ocupado, 0);
  endtask

  // Line decoder: rebuilds each digit from pulse lengths and checks it
  // against the oldest accepted digit.
  always @(negedge clk) begin
    if (reset) begin
      run_alto  = 0;
      run_baixo = 0;
      nsimb     = 0;
      cod       = '0;
    end else if (linha) begin
      if (nsimb != 0 && run_baixo != 0) checkOutput("pausa_simbolo", run_baixo, 2);
      run_alto++;
      run_baixo = 0;
    end else begin
      if (run_alto != 0) begin
        checkOutput("duracao_simbolo", (run_alto == 2) || (run_alto == 6), 1);
        cod = {cod[3:0], (run_alto == 6)};
        nsimb++;
        run_alto = 0;
      end
      run_baixo++;
      if (run_baixo == 3 && nsimb != 0) begin
        esperado = (sb.size() != 0) ? {3'd5, sb.pop_front()} : 8'hff;
        checkOutput("digito_serial", {nsimb[2:0], cod}, esperado);
        checkOutput("s1_envio", s1, esperado[4:0]);
        nsimb = 0;
        cod   = '0;
      end
    end
  end

  initial begin
    reset  = 1'b1;
    ready  = 1'b1;
    digito = 4'd3;
    repeat (3) @(negedge clk);
    checkOutput("reset_linha", linha, 0);
    checkOutput("reset_s1", s1, 0);
    checkOutput("reset_ocupado", ocupado, 0);
    checkOutput("reset_aceito", aceito, 0);
    checkOutput("reset_cheio", cheio, 0);
    reset = 1'b0;

    $display("[TB] digit 3 written with ready held through reset");
    applyStimulus(4'd3, 1'b1);
    checkOutput("latencia_linha", linha, 0);
    checkOutput("latencia_ocupado", ocupado, 1);
    @(negedge clk);
    checkOutput("linha_apos_pop", linha, 1);
    checkOutput("s1_digito3", s1, 5'b00011);
    waitIdle(400, n);

    $display("[TB] digit 5 timing");
    applyStimulus(4'd5, 1'b1);
    waitRise(50);
    checkOutput("s1_digito5", s1, 5'b00000);
    waitIdle(400, n);
    checkOutput("duracao_digito5", n, 24);
    checkOutput("s1_ocioso", s1, 0);

    $display("[TB] digit 0 timing");
    applyStimulus(4'd0, 1'b1);
    waitRise(50);
    checkOutput("s1_digito0", s1, 5'b11111);
    waitIdle(400, n);
    checkOutput("duracao_digito0", n, 44);

    $display("[TB] back-to-back writes until full");
    applyStimulus(4'd1, 1'b1);
    applyStimulus(4'd2, 1'b1);
    applyStimulus(4'd3, 1'b1);
    applyStimulus(4'd4, 1'b1);
    applyStimulus(4'd5, 1'b1);
    checkOutput("cheio", cheio, 1);
    applyStimulus(4'd6, 1'b0);
    checkOutput("cheio_mantido", cheio, 1);
    waitIdle(2000, n);
    checkOutput("scoreboard_esvaziado", sb.size(), 0);

    $display("[TB] invalid digits");
    applyStimulus(4'd12, 1'b0);
    applyStimulus(4'd15, 1'b0);
    @(negedge clk);
    checkOutput("erro_pulso_unico", erro, 0);
    checkOutput("invalido_linha", linha, 0);
    checkOutput("invalido_ocupado", ocupado, 0);
    checkOutput("invalido_cheio", cheio, 0);

    $display("[TB] reset during a dash with digits queued");
    applyStimulus(4'd8, 1'b1);
    applyStimulus(4'd7, 1'b1);
    applyStimulus(4'd9, 1'b1);
    @(negedge clk);
    checkOutput("traco_em_curso", linha, 1);
    checkOutput("s1_digito8", s1, 5'b11100);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_async_linha", linha, 0);
    checkOutput("reset_async_s1", s1, 0);
    checkOutput("reset_async_ocupado", ocupado, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    altos = 0;
    repeat (300) begin
      @(negedge clk);
      if (linha) altos++;
    end
    checkOutput("sem_envio_pos_reset", altos, 0);
    checkOutput("ocupado_pos_reset", ocupado, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
